// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: accepts a one-cycle strobe, waits WAIT_CYCLES,
// performs a load or read-modify-write store on a word RAM, then pulses done.
module dmem_responder #(
  parameter int DEPTH       = 1024,
  parameter int AW          = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic [5:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  state_t         state_reg, state_next;
  logic [3:0]     wait_cnt_reg;
  logic [5:0]     op_reg;
  logic [AW+1:0]  addr_reg;
  logic [31:0]    wdata_reg;
  logic [31:0]    rdata_reg;
  logic           err_reg;

  logic [31:0]    ram [DEPTH];
  logic [31:0]    ram_q;
  logic [AW-1:0]  rd_idx;
  logic           ram_we;

  logic           accept;
  logic           is_load, is_store, is_signed, bad_op, misaligned, acc_err;
  logic [1:0]     size;
  logic [31:0]    shifted, load_val, wsrc, merged;
  logic [3:0]     be;

  // Upper address bits only select aliases of the same word.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[31:AW+2];

  assign accept = (state_reg == S_IDLE) && mem_req;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (mem_req) state_next = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
      S_WAIT:   if (wait_cnt_reg == 4'd0) state_next = S_ACCESS;
      S_ACCESS: state_next = S_RESP;
      S_RESP:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_signed = 1'b0;
    bad_op    = 1'b0;
    size      = SZ_WORD;
    case (op_reg)
      OP_LB:   begin is_load  = 1'b1; size = SZ_BYTE; is_signed = 1'b1; end
      OP_LBU:  begin is_load  = 1'b1; size = SZ_BYTE; end
      OP_LH:   begin is_load  = 1'b1; size = SZ_HALF; is_signed = 1'b1; end
      OP_LHU:  begin is_load  = 1'b1; size = SZ_HALF; end
      OP_LW:   begin is_load  = 1'b1; size = SZ_WORD; end
      OP_SB:   begin is_store = 1'b1; size = SZ_BYTE; end
      OP_SH:   begin is_store = 1'b1; size = SZ_HALF; end
      OP_SW:   begin is_store = 1'b1; size = SZ_WORD; end
      default: bad_op = 1'b1;
    endcase
  end

  assign misaligned = ((size == SZ_HALF) && addr_reg[0]) ||
                      ((size == SZ_WORD) && (addr_reg[1:0] != 2'b00));
  assign acc_err    = bad_op || misaligned;

  // Load extraction: bring the addressed lane down to bit 0, then extend.
  assign shifted = ram_q >> {addr_reg[1:0], 3'b000};
  always_comb begin
    load_val = ram_q;
    if (size == SZ_BYTE)
      load_val = {{24{is_signed & shifted[7]}}, shifted[7:0]};
    else if (size == SZ_HALF)
      load_val = {{16{is_signed & shifted[15]}}, shifted[15:0]};
  end

  assign wsrc = (size == SZ_BYTE) ? {4{wdata_reg[7:0]}} :
                (size == SZ_HALF) ? {2{wdata_reg[15:0]}} : wdata_reg;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign be[gi] = (size == SZ_WORD) ||
                      ((size == SZ_HALF) && (addr_reg[1] == LANE[1])) ||
                      ((size == SZ_BYTE) && (addr_reg[1:0] == LANE));
      assign merged[8*gi +: 8] = be[gi] ? wsrc[8*gi +: 8] : ram_q[8*gi +: 8];
    end
  endgenerate

  // Read the incoming address at acceptance so the word is ready even with no wait states.
  assign rd_idx = (state_reg == S_IDLE) ? addr[AW+1:2] : addr_reg[AW+1:2];
  assign ram_we = (state_reg == S_ACCESS) && !rst && is_store && !acc_err;

  always_ff @(posedge clk) begin
    if (ram_we) ram[addr_reg[AW+1:2]] <= merged;
    ram_q <= ram[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_reg <= 4'd0;
      op_reg       <= 6'd0;
      addr_reg     <= '0;
      wdata_reg    <= 32'd0;
      rdata_reg    <= 32'd0;
      err_reg      <= 1'b0;
    end else begin
      if (accept) begin
        op_reg       <= op;
        addr_reg     <= addr[AW+1:0];
        wdata_reg    <= wdata;
        wait_cnt_reg <= 4'(WAIT_CYCLES - 1);
      end
      if (state_reg == S_WAIT && wait_cnt_reg != 4'd0)
        wait_cnt_reg <= wait_cnt_reg - 4'd1;
      if (state_reg == S_ACCESS) begin
        err_reg <= acc_err;
        if (acc_err)      rdata_reg <= 32'd0;
        else if (is_load) rdata_reg <= load_val;
      end
      if (state_reg == S_RESP)
        err_reg <= 1'b0;
    end
  end

  assign busy  = (state_reg != S_IDLE);
  assign done  = (state_reg == S_RESP);
  assign err   = err_reg;
  assign rdata = rdata_reg;

endmodule
